// File: rtl/pc_sequencer_if.sv
// Fetch and execute handshake bundle between pc_sequencer,
// instruction memory and the decoder/datapath.
interface pc_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             fetch_req;
    logic [WIDTH-1:0] fetch_addr;
    logic             fetch_ack;
    logic [WIDTH-1:0] instr_in;
    logic [WIDTH-1:0] instr_out;
    logic             instr_valid;
    logic             exec_done;
    logic             ctl_jump;
    logic             ctl_branch;
    logic             ctl_jal;
    logic [3:0]       cond;
    logic [4:0]       psr_flags;
    logic [WIDTH-1:0] src2;
    logic             halt;

    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_ack,
        input  instr_in,
        output instr_out,
        output instr_valid,
        input  exec_done,
        input  ctl_jump,
        input  ctl_branch,
        input  ctl_jal,
        input  cond,
        input  psr_flags,
        input  src2,
        input  halt
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_ack,
        output instr_in,
        input  instr_out,
        input  instr_valid,
        output exec_done,
        output ctl_jump,
        output ctl_branch,
        output ctl_jal,
        output cond,
        output psr_flags,
        output src2,
        output halt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multicycle PC controller: FETCH -> EXEC -> UPDATE (-> HALT).
// Optional PC_BRANCH_STATS_EN adds a saturating taken_count output.
module pc_sequencer #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             reset,
    pc_sequencer_if.master   bus,
    output logic             link_we,
    output logic [WIDTH-1:0] link_data,
    output logic [WIDTH-1:0] pc,
`ifdef PC_BRANCH_STATS_EN
    output logic [WIDTH-1:0] taken_count,
`endif
    output logic             halted
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_EXEC   = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] target;
    logic             cond_true;
    logic             n_f, z_f, f_f, l_f, c_f;

    assign {n_f, z_f, f_f, l_f, c_f} = bus.psr_flags;
    assign pc_inc         = pc + WIDTH'(1);
    assign bus.fetch_addr = pc;

    always_comb begin
        cond_true = 1'b0;
        case (bus.cond)
            4'h0: cond_true = z_f;
            4'h1: cond_true = !z_f;
            4'h2: cond_true = c_f;
            4'h3: cond_true = !c_f;
            4'h4: cond_true = l_f;
            4'h5: cond_true = !l_f;
            4'h6: cond_true = n_f;
            4'h7: cond_true = !n_f;
            4'h8: cond_true = f_f;
            4'h9: cond_true = !f_f;
            4'hA: cond_true = !l_f && !z_f;
            4'hB: cond_true = l_f || z_f;
            4'hC: cond_true = !n_f && !z_f;
            4'hD: cond_true = n_f || z_f;
            4'hE: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // jal outranks jump, which outranks branch
    always_comb begin
        target = pc_inc;
        if (bus.ctl_jal) begin
            target = bus.src2;
        end else if (bus.ctl_jump) begin
            if (cond_true) target = bus.src2;
        end else if (bus.ctl_branch) begin
            if (cond_true) target = pc + bus.src2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_FETCH;
            pc              <= RESET_VECTOR;
            next_pc         <= RESET_VECTOR;
            bus.instr_out   <= '0;
            bus.fetch_req   <= 1'b0;
            bus.instr_valid <= 1'b0;
            link_we         <= 1'b0;
            link_data       <= '0;
            halted          <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.fetch_req && bus.fetch_ack) begin
                        bus.instr_out   <= bus.instr_in;
                        bus.fetch_req   <= 1'b0;
                        bus.instr_valid <= 1'b1;
                        state           <= S_EXEC;
                    end else begin
                        bus.fetch_req <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (bus.exec_done) begin
                        next_pc         <= target;
                        link_we         <= bus.ctl_jal;
                        bus.instr_valid <= 1'b0;
                        state           <= S_UPDATE;
                        if (bus.ctl_jal) link_data <= pc_inc;
                    end
                end
                S_UPDATE: begin
                    pc      <= next_pc;
                    link_we <= 1'b0;
                    if (bus.halt) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                default: begin
                    if (!bus.halt) begin
                        halted <= 1'b0;
                        state  <= S_FETCH;
                    end
                end
            endcase
        end
    end

`ifdef PC_BRANCH_STATS_EN
    logic taken;
    logic taken_q;

    assign taken = bus.ctl_jal
                 || ((bus.ctl_jump || bus.ctl_branch) && cond_true);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taken_q     <= 1'b0;
            taken_count <= '0;
        end else begin
            if (state == S_EXEC && bus.exec_done) taken_q <= taken;
            if (state == S_UPDATE && taken_q && !(&taken_count))
                taken_count <= taken_count + WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer with a few
// hand-written multi-cycle sequences (waits, halt, reset).
module tb_pc_sequencer;
    localparam int          W  = 16;
    localparam logic [15:0] RV = 16'h0010;

    logic        clk = 1'b0;
    logic        reset;
    logic        link_we;
    logic [15:0] link_data;
    logic [15:0] pc;
    logic        halted;
`ifdef PC_BRANCH_STATS_EN
    logic [15:0] taken_count;
`endif

    always #5 clk = ~clk;

    pc_sequencer_if #(.WIDTH(W)) bus ();

    pc_sequencer #(.WIDTH(W), .RESET_VECTOR(RV)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master),
        .link_we(link_we),
        .link_data(link_data),
        .pc(pc),
`ifdef PC_BRANCH_STATS_EN
        .taken_count(taken_count),
`endif
        .halted(halted)
    );

    typedef struct {
        logic        jal;
        logic        jump;
        logic        branch;
        logic [3:0]  c;
        logic [4:0]  fl;
        logic [15:0] s2;
        logic [15:0] exp_pc;
    } vec_t;

    localparam int NV = 30;
    vec_t v[NV];

    localparam logic [4:0] FN = 5'b10000;
    localparam logic [4:0] FZ = 5'b01000;
    localparam logic [4:0] FF = 5'b00100;
    localparam logic [4:0] FL = 5'b00010;
    localparam logic [4:0] FC = 5'b00001;
    localparam logic [4:0] F0 = 5'b00000;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_ctl();
        bus.exec_done  = 1'b0;
        bus.ctl_jal    = 1'b0;
        bus.ctl_jump   = 1'b0;
        bus.ctl_branch = 1'b0;
        bus.cond       = 4'h0;
        bus.psr_flags  = 5'b0;
        bus.src2       = 16'h0;
    endtask

    task automatic wait_fetch(input string tag, output bit ok);
        int t;
        t = 0;
        while (bus.fetch_req !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        ok = (bus.fetch_req === 1'b1);
        if (!ok) check({tag, " fetch_req timeout"}, 0, 1);
    endtask

    task automatic run_instr(input string tag, input logic jal,
                             input logic jump, input logic branch,
                             input logic [3:0] c, input logic [4:0] fl,
                             input logic [15:0] s2,
                             input logic [15:0] start_pc,
                             input logic [15:0] exp_pc,
                             input int waits, input logic hlt);
        bit ok;
        int pulses;
        wait_fetch(tag, ok);
        if (!ok) return;
        check({tag, " fetch_addr"}, bus.fetch_addr, start_pc);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check({tag, " wait fetch_req"}, bus.fetch_req, 1);
            check({tag, " wait fetch_addr"}, bus.fetch_addr, start_pc);
        end
        bus.instr_in  = start_pc ^ 16'hA5A5;
        bus.fetch_ack = 1'b1;
        @(negedge clk);
        bus.fetch_ack = 1'b0;
        check({tag, " instr_valid"}, bus.instr_valid, 1);
        check({tag, " instr_out"}, bus.instr_out, start_pc ^ 16'hA5A5);
        bus.ctl_jal    = jal;
        bus.ctl_jump   = jump;
        bus.ctl_branch = branch;
        bus.cond       = c;
        bus.psr_flags  = fl;
        bus.src2       = s2;
        bus.halt       = hlt;
        bus.exec_done  = 1'b1;
        @(negedge clk);
        clear_ctl();
        pulses = int'(link_we);
        if (jal) check({tag, " link_data"}, link_data, start_pc + 16'd1);
        @(negedge clk);
        pulses += int'(link_we);
        check({tag, " link pulses"}, pulses, int'(jal));
        check({tag, " pc"}, pc, exp_pc);
        check({tag, " instr_valid low"}, bus.instr_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cur;
        bit ok;

        v[0]  = '{0, 1, 0, 4'hE, F0, 16'h0020, 16'h0020};
        v[1]  = '{0, 0, 1, 4'h0, FZ, 16'hFFFC, 16'h001C};
        v[2]  = '{0, 1, 0, 4'hE, F0, 16'h0020, 16'h0020};
        v[3]  = '{0, 0, 1, 4'h0, F0, 16'hFFFC, 16'h0021};
        v[4]  = '{0, 1, 0, 4'hE, F0, 16'h0030, 16'h0030};
        v[5]  = '{1, 0, 0, 4'h0, F0, 16'h0100, 16'h0100};
        v[6]  = '{0, 1, 0, 4'hE, F0, 16'h0040, 16'h0040};
        v[7]  = '{0, 1, 0, 4'hC, F0, 16'h0200, 16'h0200};
        v[8]  = '{0, 1, 0, 4'hE, F0, 16'h0040, 16'h0040};
        v[9]  = '{0, 1, 0, 4'hF, F0, 16'h0300, 16'h0041};
        v[10] = '{0, 1, 0, 4'hE, F0, 16'h0040, 16'h0040};
        v[11] = '{0, 1, 0, 4'hE, F0, 16'h0500, 16'h0500};
        v[12] = '{0, 1, 0, 4'hE, F0, 16'hFFFF, 16'hFFFF};
        v[13] = '{0, 0, 0, 4'hE, F0, 16'h1234, 16'h0000};
        v[14] = '{0, 1, 0, 4'hE, F0, 16'hFFFE, 16'hFFFE};
        v[15] = '{0, 0, 1, 4'hE, F0, 16'h0005, 16'h0003};
        v[16] = '{1, 1, 1, 4'hF, F0, 16'h0777, 16'h0777};
        v[17] = '{0, 1, 1, 4'h0, FZ, 16'h0010, 16'h0010};
        v[18] = '{0, 1, 0, 4'h5, F0, 16'h0050, 16'h0050};
        v[19] = '{0, 0, 1, 4'hB, F0, 16'h0003, 16'h0051};
        v[20] = '{0, 0, 1, 4'hD, FN, 16'h0002, 16'h0053};
        v[21] = '{0, 0, 1, 4'h1, FZ, 16'h0004, 16'h0054};
        v[22] = '{0, 0, 1, 4'hA, F0, 16'h0010, 16'h0064};
        v[23] = '{0, 0, 1, 4'h2, FC, 16'h0001, 16'h0065};
        v[24] = '{0, 0, 1, 4'h3, FC, 16'h0001, 16'h0066};
        v[25] = '{0, 0, 1, 4'h8, FF, 16'h0002, 16'h0068};
        v[26] = '{0, 0, 1, 4'h6, F0, 16'h0002, 16'h0069};
        v[27] = '{0, 0, 1, 4'h4, FL, 16'h0003, 16'h006C};
        v[28] = '{0, 0, 1, 4'h9, F0, 16'h0003, 16'h006F};
        v[29] = '{0, 0, 1, 4'h7, F0, 16'h0004, 16'h0073};

        reset         = 1'b0;
        bus.fetch_ack = 1'b0;
        bus.instr_in  = 16'h0;
        bus.halt      = 1'b0;
        clear_ctl();
        repeat (2) @(negedge clk);
        check("rst pc", pc, RV);
        check("rst fetch_req", bus.fetch_req, 0);
        check("rst instr_valid", bus.instr_valid, 0);
        check("rst instr_out", bus.instr_out, 0);
        check("rst link_we", link_we, 0);
        check("rst link_data", link_data, 0);
        check("rst halted", halted, 0);
        reset = 1'b1;

        run_instr("first", 0, 0, 0, 4'h0, F0, 16'h0, RV, 16'h0011, 2, 0);

        cur = 16'h0011;
        for (int i = 0; i < NV; i++) begin
            run_instr($sformatf("vec%0d", i), v[i].jal, v[i].jump,
                      v[i].branch, v[i].c, v[i].fl, v[i].s2, cur,
                      v[i].exp_pc, i % 3, 0);
            cur = v[i].exp_pc;
        end

        run_instr("halt", 0, 0, 0, 4'h0, F0, 16'h0, cur, 16'h0074, 0, 1);
        check("halt halted", halted, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("halt no fetch_req", bus.fetch_req, 0);
            check("halt held", halted, 1);
        end
        bus.halt = 1'b0;
        @(negedge clk);
        check("unhalt halted", halted, 0);
        run_instr("after halt", 0, 0, 0, 4'h0, F0, 16'h0, 16'h0074,
                  16'h0075, 0, 0);

        wait_fetch("rst jal", ok);
        if (ok) begin
            bus.instr_in  = 16'hBEEF;
            bus.fetch_ack = 1'b1;
            @(negedge clk);
            bus.fetch_ack = 1'b0;
            check("rst jal in exec", bus.instr_valid, 1);
            bus.ctl_jal = 1'b1;
            bus.src2    = 16'h0900;
            reset       = 1'b0;
            #1;
            check("rst jal pc", pc, RV);
            check("rst jal instr_valid", bus.instr_valid, 0);
            check("rst jal instr_out", bus.instr_out, 0);
            check("rst jal fetch_req", bus.fetch_req, 0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("rst jal link_we", link_we, 0);
                check("rst jal pc hold", pc, RV);
            end
            clear_ctl();
            reset = 1'b1;
            run_instr("post rst", 0, 0, 0, 4'h0, F0, 16'h0, RV,
                      16'h0011, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multicycle program-counter controller for the 16-bit datapath.
- Owns the architectural PC register and sequences each instruction: fetch handshake with instruction memory, execute handshake with the datapath, branch/jump condition evaluation against PSR flags, next-PC selection, JAL link write-back.
- Sits between instruction memory, the decoder/datapath and the register file link port.

Parameters:
WIDTH, 16, PC/address/data width
RESET_VECTOR, 16'h0000, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
fetch_req  output  1  instruction fetch request
fetch_addr  output  WIDTH  fetch address (= PC)
fetch_ack  input  1  memory has placed instruction on instr_in
instr_in  input  WIDTH  fetched instruction word
instr_out  output  WIDTH  latched instruction to decoder/datapath
instr_valid  output  1  instr_out valid, execute in progress
exec_done  input  1  datapath finished; ctl_* and operands valid this cycle
ctl_jump  input  1  Jcond instruction
ctl_branch  input  1  Bcond instruction
ctl_jal  input  1  JAL instruction
cond  input  4  condition field
psr_flags  input  5  {N,Z,F,L,C}
src2  input  WIDTH  jump target (jump/JAL) or signed displacement (branch)
halt  input  1  stop after current instruction
link_we  output  1  register-file write strobe for link
link_data  output  WIDTH  link value (PC+1)
pc  output  WIDTH  current PC
halted  output  1  sequencer idle in HALT

Behaviour:
- States: FETCH, EXEC, UPDATE, HALT. Reset → FETCH.
- Reset values:
  - pc=RESET_VECTOR
  - instr_out=0
  - fetch_req=0, instr_valid=0, link_we=0, link_data=0, halted=0
  - internal next_pc=RESET_VECTOR
- FETCH: fetch_req=1, fetch_addr=pc.
  - On fetch_ack: latch instr_in→instr_out, drop fetch_req next cycle, go EXEC.
  - Without ack: fetch_req stays high and fetch_addr stays stable.
- EXEC: instr_valid=1; wait for exec_done. On exec_done, register next_pc:
  - ctl_jal: next_pc=src2. Link write is unconditional.
  - else ctl_jump: next_pc = cond_true ? src2 : pc+1.
  - else ctl_branch: next_pc = cond_true ? pc+src2 : pc+1. Addition is WIDTH-bit two's complement; wraps modulo 2^WIDTH, no overflow detection.
  - else: next_pc=pc+1; pc+1 at max address wraps to 0.
  - Priority when several ctl_* are high: jal > jump > branch.
  - Go UPDATE.
- UPDATE (exactly one cycle): pc<=next_pc, instr_valid=0.
  - If JAL: link_we=1 for this cycle only, link_data=old pc+1 (old PC wraps).
  - Then: halt=1 → HALT, else → FETCH.
- HALT: halted=1, no requests. When halt=0, go FETCH next cycle.
- cond_true is evaluated on psr_flags sampled in the exec_done cycle:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: L
  - 5 LS: !L
  - 6 GT: N
  - 7 LE: !N
  - 8 FS: F
  - 9 FC: !F
  - A LO: !L&!Z
  - B HS: L|Z
  - C LT: !N&!Z
  - D GE: N|Z
  - E UC: 1
  - F: 0
- Latency: a non-taken instruction with zero-wait memory and a one-cycle execute takes 4 cycles (FETCH, FETCH-ack, EXEC/done, UPDATE).
- fetch_ack outside FETCH and exec_done outside EXEC are ignored.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight request is abandoned and no link write occurs.

Optional Feature:
- Macro: PC_BRANCH_STATS_EN.
- When defined, adds output port taken_count (WIDTH bits):
  - Counts taken jumps, taken branches and JALs, incremented in UPDATE.
  - Saturates at all-ones.
  - Cleared by reset.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset with RESET_VECTOR=16'h0010, release, ack fetch after 2 wait cycles → fetch_addr=0x0010 held stable, fetch_req held through the waits; after exec_done, pc=0x0011.
- pc=0x0020, ctl_branch, cond=0 (EQ), Z=1, src2=16'hFFFC → pc=0x001C. Repeat with Z=0 → pc=0x0021.
- pc=0x0030, ctl_jal, src2=0x0100 → pc=0x0100, link_we single-cycle pulse with link_data=0x0031.
- pc=0x0040, ctl_jump, cond=0xC (LT) with N=0,Z=0 → pc=src2; cond=0xF → pc=0x0041; cond=0xE → pc=src2.
- pc=0xFFFF normal instruction → pc=0x0000. Branch at pc=0xFFFE with src2=0x0005 → pc=0x0003.
- Reset asserted during EXEC of a JAL → no link_we, pc=RESET_VECTOR. halt=1 during EXEC → halted=1 after UPDATE, no fetch_req until halt=0.
